// File: rtl/wbarbiter_wdt.sv
// Two-master pipelined Wishbone arbiter with registered grant.
// Optional bus watchdog enabled by defining WBARB_WATCHDOG_EN.
module wbarbiter_wdt #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int PRIORITY_A = 0,
    parameter int LGTIMEOUT  = 19
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_a_cyc,
    input  logic          i_a_stb,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [DW-1:0] i_a_data,
    output logic          o_a_ack,
    output logic          o_a_stall,
    output logic          o_a_err,
    input  logic          i_b_cyc,
    input  logic          i_b_stb,
    input  logic          i_b_we,
    input  logic [AW-1:0] i_b_addr,
    input  logic [DW-1:0] i_b_data,
    output logic          o_b_ack,
    output logic          o_b_stall,
    output logic          o_b_err,
    output logic          o_cyc,
    output logic          o_stb,
    output logic          o_we,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data,
    input  logic          i_ack,
    input  logic          i_stall,
    input  logic          i_err,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_rdata,
    output logic [1:0]    o_owner
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OWN_A = 2'd1;
    localparam logic [1:0] S_OWN_B = 2'd2;
    localparam logic [1:0] S_LOCK  = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       r_last_b;
    logic       w_cyc;
    logic       w_timeout;
    logic       w_a_wins;

    // Read data is shared; only the ack tells a master it is theirs.
    assign o_rdata = i_data;

    // Slave CYC follows the current owner's CYC only.
    assign w_cyc = (r_state == S_OWN_A) ? i_a_cyc :
                   (r_state == S_OWN_B) ? i_b_cyc : 1'b0;

    // On a tie A wins under fixed priority or if B owned the bus last.
    assign w_a_wins = (PRIORITY_A != 0) || r_last_b;

`ifdef WBARB_WATCHDOG_EN
    localparam logic [LGTIMEOUT-1:0] WDT_HIT = {{(LGTIMEOUT-1){1'b1}}, 1'b0};

    logic [LGTIMEOUT-1:0] r_wdt;

    // Terminal cycle: counter would reach all-ones this cycle; an ack wins.
    assign w_timeout = w_cyc && !i_ack && (r_wdt == WDT_HIT);

    // Count cycles of an open bus cycle without an acknowledgement.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_wdt <= '0;
        else if (!w_cyc || i_ack || w_timeout)
            r_wdt <= '0;
        else
            r_wdt <= r_wdt + 1'b1;
    end
`else
    logic w_unused_lg;

    assign w_timeout   = 1'b0;
    assign w_unused_lg = (LGTIMEOUT > 0);
`endif

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Remember who owned the bus last, for round-robin ties and LOCKOUT.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_last_b <= 1'b1;
        else if (r_state == S_OWN_A && w_next != S_OWN_A)
            r_last_b <= 1'b0;
        else if (r_state == S_OWN_B && w_next != S_OWN_B)
            r_last_b <= 1'b1;
    end

    // Next-state logic; every owner change passes through IDLE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_a_cyc && (!i_b_cyc || w_a_wins))
                    w_next = S_OWN_A;
                else if (i_b_cyc)
                    w_next = S_OWN_B;
            end
            S_OWN_A: begin
                if (!i_a_cyc)
                    w_next = S_IDLE;
                else if (w_timeout)
                    w_next = S_LOCK;
            end
            S_OWN_B: begin
                if (!i_b_cyc)
                    w_next = S_IDLE;
                else if (w_timeout)
                    w_next = S_LOCK;
            end
            S_LOCK: begin
                if (r_last_b ? !i_b_cyc : !i_a_cyc)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output mux on the registered owner; non-owners are stalled.
    always_comb begin
        o_cyc     = w_cyc;
        o_stb     = 1'b0;
        o_we      = 1'b0;
        o_addr    = '0;
        o_data    = '0;
        o_a_ack   = 1'b0;
        o_a_err   = 1'b0;
        o_a_stall = 1'b1;
        o_b_ack   = 1'b0;
        o_b_err   = 1'b0;
        o_b_stall = 1'b1;
        o_owner   = 2'b00;
        unique case (r_state)
            S_OWN_A: begin
                o_stb     = i_a_stb;
                o_we      = i_a_we;
                o_addr    = i_a_addr;
                o_data    = i_a_data;
                o_a_stall = i_stall;
                o_a_ack   = i_ack;
                o_a_err   = i_err || w_timeout;
                o_owner   = 2'b01;
            end
            S_OWN_B: begin
                o_stb     = i_b_stb;
                o_we      = i_b_we;
                o_addr    = i_b_addr;
                o_data    = i_b_data;
                o_b_stall = i_stall;
                o_b_ack   = i_ack;
                o_b_err   = i_err || w_timeout;
                o_owner   = 2'b10;
            end
            S_LOCK: begin
                o_owner = r_last_b ? 2'b10 : 2'b01;
            end
            default: begin
                o_owner = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_wbarbiter_wdt.sv
// Testbench for wbarbiter_wdt: scoreboarded two-master traffic,
// handoff ordering, reset abort and (with the macro) watchdog cases.
module tb_wbarbiter_wdt;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_a_cyc, i_a_stb, i_a_we;
    logic [31:0] i_a_addr, i_a_data;
    logic        o_a_ack, o_a_stall, o_a_err;
    logic        i_b_cyc, i_b_stb, i_b_we;
    logic [31:0] i_b_addr, i_b_data;
    logic        o_b_ack, o_b_stall, o_b_err;
    logic        o_cyc, o_stb, o_we;
    logic [31:0] o_addr, o_data;
    logic        i_ack, i_stall, i_err;
    logic [31:0] i_data, o_rdata;
    logic [1:0]  o_owner;

    always #5 clk = ~clk;

    wbarbiter_wdt #(
        .AW(32), .DW(32), .PRIORITY_A(0), .LGTIMEOUT(4)
    ) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we),
        .i_a_addr(i_a_addr), .i_a_data(i_a_data),
        .o_a_ack(o_a_ack), .o_a_stall(o_a_stall), .o_a_err(o_a_err),
        .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we),
        .i_b_addr(i_b_addr), .i_b_data(i_b_data),
        .o_b_ack(o_b_ack), .o_b_stall(o_b_stall), .o_b_err(o_b_err),
        .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we),
        .o_addr(o_addr), .o_data(o_data),
        .i_ack(i_ack), .i_stall(i_stall), .i_err(i_err),
        .i_data(i_data), .o_rdata(o_rdata), .o_owner(o_owner)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Scoreboard: expected ack owner and read data, in issue order.
    bit          exp_b[$];
    logic [31:0] exp_d[$];
    int          pend_a = 0, pend_b = 0;

    // Slave model state.
    int          s_lat = 1;
    bit          s_hang = 0;
    logic [31:0] s_q[$];
    int          s_t[$];
    int          cyc_n = 0;

    // Monitor state.
    int         n_stb_b = 0, n_ack_a = 0, n_ack_b = 0;
    int         n_err_a = 0, n_err_b = 0, n_viol = 0;
    int         cyc_run = 0, err_at = 0;
    logic [1:0] own_tr[$];

    // Slave: answers each accepted strobe s_lat cycles later.
    always @(posedge clk) begin
        cyc_n++;
        #1;
        if (!s_hang) begin
            i_ack = 1'b0;
            if (s_t.size() > 0 && s_t[0] <= cyc_n) begin
                i_ack  = 1'b1;
                i_data = rd_of(s_q.pop_front());
                void'(s_t.pop_front());
            end
        end
    end

    // Monitor: bus observations and scoreboard pops.
    always @(negedge clk) begin
        if (!i_reset) begin
            cyc_run = o_cyc ? cyc_run + 1 : 0;
            own_tr.push_back(o_owner);
            if (!s_hang && o_cyc && o_stb && !i_stall) begin
                s_q.push_back(o_addr);
                s_t.push_back(cyc_n + s_lat);
            end
            if (o_cyc && o_stb && !i_stall && o_owner == 2'b10)
                n_stb_b++;
            if (o_a_err) begin
                n_err_a++;
                err_at = cyc_run;
            end
            if (o_b_err)
                n_err_b++;
            if (o_owner != 2'b01 && (!o_a_stall || o_a_ack || o_a_err))
                n_viol++;
            if (o_owner != 2'b10 && (!o_b_stall || o_b_ack || o_b_err))
                n_viol++;
            if (o_a_ack || o_b_ack) begin
                if (o_a_ack) n_ack_a++;
                if (o_b_ack) n_ack_b++;
                if (exp_b.size() == 0) begin
                    check("spurious_ack", {o_a_ack, o_b_ack}, 0);
                end else begin
                    automatic bit          eb = exp_b.pop_front();
                    automatic logic [31:0] ed = exp_d.pop_front();
                    check("ack_owner", {o_a_ack, o_b_ack},
                          eb ? 2'b01 : 2'b10);
                    check("rdata", o_rdata, ed);
                    if (eb) pend_b--; else pend_a--;
                end
            end
        end
    end

    task automatic drv(input bit b, input logic c, input logic s,
                       input logic w, input logic [31:0] a);
        if (b) begin
            i_b_cyc = c; i_b_stb = s; i_b_we = w;
            i_b_addr = a; i_b_data = ~a;
        end else begin
            i_a_cyc = c; i_a_stb = s; i_a_we = w;
            i_a_addr = a; i_a_data = ~a;
        end
    endtask

    // One master cycle: n pipelined strobes, wait all acks, drop CYC.
    task automatic run_master(input bit b, input int n,
                              input logic [31:0] base, input bit we);
        int k = 0;
        int g = 0;
        drv(b, 1'b1, 1'b1, we, base);
        while (k < n && g < 200) begin
            @(negedge clk);
            if (!(b ? o_b_stall : o_a_stall)) begin
                exp_b.push_back(b);
                exp_d.push_back(rd_of(base + 32'(k * 4)));
                if (b) pend_b++; else pend_a++;
                k++;
            end
            @(posedge clk);
            #1;
            if (k < n)
                drv(b, 1'b1, 1'b1, we, base + 32'(k * 4));
            else
                drv(b, 1'b1, 1'b0, we, base);
            g++;
        end
        check(b ? "b_strobes" : "a_strobes", k, n);
        g = 0;
        while ((b ? pend_b : pend_a) > 0 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        check(b ? "b_acks_done" : "a_acks_done", b ? pend_b : pend_a, 0);
        drv(b, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    function automatic logic [1:0] first_own();
        for (int j = 0; j < own_tr.size(); j++)
            if (own_tr[j] != 2'b00) return own_tr[j];
        return 2'b11;
    endfunction

    // Owner codes in the two cycles after B's last ownership cycle.
    function automatic logic [3:0] after_b();
        int i = -1;
        for (int j = 0; j < own_tr.size(); j++)
            if (own_tr[j] == 2'b10) i = j;
        if (i < 0 || i + 2 >= own_tr.size()) return 4'hF;
        return {own_tr[i+1], own_tr[i+2]};
    endfunction

    task automatic wait_owner(input logic [1:0] own);
        int g = 0;
        while (o_owner != own && g < 50) begin
            @(negedge clk);
            #1;
            g++;
        end
        check("wait_owner", o_owner, own);
    endtask

    initial begin
        #300000;
        n_chk++;
        n_fail++;
        $display("FAIL global_timeout t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        int s0, a0, b0, e0, g;
        i_reset = 1'b1;
        drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        i_ack = 1'b0; i_stall = 1'b0; i_err = 1'b0; i_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_owner", o_owner, 2'b00);
        check("rst_cyc", {o_cyc, o_stb}, 2'b00);
        check("rst_stall", {o_a_stall, o_b_stall}, 2'b11);
        check("rst_ack_err", {o_a_ack, o_b_ack, o_a_err, o_b_err}, 4'h0);
        @(posedge clk);
        #1;
        i_reset = 1'b0;

        // Single read by A with a 2-cycle slave.
        s_lat = 2;
        own_tr.delete();
        s0 = n_stb_b; a0 = n_ack_a; b0 = n_ack_b;
        fork
            run_master(1'b0, 1, 32'h100, 1'b0);
            begin
                @(negedge clk);
                check("t1_req_owner", o_owner, 2'b00);
                check("t1_req_stall", o_a_stall, 1'b1);
                check("t1_req_stb", o_stb, 1'b0);
                @(negedge clk);
                check("t1_grant", o_owner, 2'b01);
            end
        join
        check("t1_a_acks", n_ack_a - a0, 1);
        check("t1_b_acks", n_ack_b - b0, 0);
        check("t1_viol", n_viol, 0);

        // Tie after A owned last: B first, one IDLE, then A.
        s_lat = 1;
        repeat (2) @(posedge clk);
        #1;
        own_tr.delete();
        fork
            run_master(1'b1, 1, 32'h200, 1'b0);
            run_master(1'b0, 1, 32'h300, 1'b0);
        join
        check("t2_first", first_own(), 2'b10);
        check("t2_handoff", after_b(), 4'b0001);
        check("t2_viol", n_viol, 0);

        // B burst with a toggling stall; A asks mid-burst.
        repeat (2) @(posedge clk);
        #1;
        own_tr.delete();
        s0 = n_stb_b; a0 = n_ack_a; b0 = n_ack_b;
        fork
            run_master(1'b1, 4, 32'h400, 1'b1);
            begin
                repeat (3) @(posedge clk);
                #1;
                run_master(1'b0, 1, 32'h500, 1'b0);
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    @(posedge clk);
                    #1;
                    i_stall = ~i_stall;
                end
                i_stall = 1'b0;
            end
        join
        check("t3_b_strobes", n_stb_b - s0, 4);
        check("t3_b_acks", n_ack_b - b0, 4);
        check("t3_a_acks", n_ack_a - a0, 1);
        check("t3_handoff", after_b(), 4'b0001);
        check("t3_viol", n_viol, 0);

        // Reset while B holds the bus with an ack outstanding.
        s_lat = 3;
        repeat (2) @(posedge clk);
        #1;
        drv(1'b1, 1'b1, 1'b1, 1'b0, 32'h600);
        @(negedge clk);
        #1;
        wait_owner(2'b10);
        @(posedge clk);
        #1;
        drv(1'b1, 1'b1, 1'b0, 1'b0, 32'h600);
        @(negedge clk);
        #2;
        i_reset = 1'b1;
        #1;
        check("t6_cyc_async", o_cyc, 1'b0);
        check("t6_owner_async", o_owner, 2'b00);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        exp_b.delete(); exp_d.delete();
        pend_a = 0; pend_b = 0;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        b0 = n_ack_b;
        repeat (5) @(posedge clk);
        #1;
        check("t6_stale_ack", n_ack_b - b0, 0);
        check("t6_owner", o_owner, 2'b00);

`ifdef WBARB_WATCHDOG_EN
        // Hung slave: err on the 15th CYC cycle, then LOCKOUT.
        s_hang = 1'b1;
        i_ack = 1'b0;
        e0 = n_err_a;
        repeat (2) @(posedge clk);
        #1;
        drv(1'b0, 1'b1, 1'b1, 1'b0, 32'h700);
        @(negedge clk);
        #1;
        wait_owner(2'b01);
        @(posedge clk);
        #1;
        drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h700);
        g = 0;
        while (n_err_a == e0 && g < 40) begin
            @(negedge clk);
            #1;
            g++;
        end
        check("t4_err_at", err_at, 15);
        @(negedge clk);
        #1;
        check("t4_cyc_off", o_cyc, 1'b0);
        check("t4_lockout", o_owner, 2'b01);
        repeat (3) @(negedge clk);
        #1;
        check("t4_err_once", n_err_a - e0, 1);
        check("t4_lock_stall", o_a_stall, 1'b1);
        @(posedge clk);
        #1;
        drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("t4_idle", o_owner, 2'b00);

        // Ack on the terminal cycle beats the watchdog.
        e0 = n_err_a; a0 = n_ack_a;
        exp_b.push_back(1'b0);
        exp_d.push_back(32'hCAFE_0005);
        pend_a++;
        @(posedge clk);
        #1;
        drv(1'b0, 1'b1, 1'b1, 1'b0, 32'h800);
        @(negedge clk);
        #1;
        wait_owner(2'b01);
        @(posedge clk);
        #1;
        drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h800);
        g = 0;
        while (cyc_run < 14 && g < 40) begin
            @(negedge clk);
            #1;
            g++;
        end
        check("t5_run", cyc_run, 14);
        @(posedge clk);
        #1;
        i_ack = 1'b1;
        i_data = 32'hCAFE_0005;
        @(posedge clk);
        #1;
        i_ack = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("t5_no_err", n_err_a - e0, 0);
        check("t5_ack", n_ack_a - a0, 1);
        check("t5_owner", o_owner, 2'b01);
        @(posedge clk);
        #1;
        drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("t5_idle", o_owner, 2'b00);
        s_hang = 1'b0;
`endif

        check("final_viol", n_viol, 0);
        check("final_b_err", n_err_b, 0);
        check("final_queue", exp_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
